// File: rtl/bank_manager_pkg.sv
// Shared definitions for the polyphonic voice bank: command opcodes,
// the top-octave tuning table and the note-to-tuning-word conversion.
package bank_manager_pkg;

  localparam int unsigned PHASE_W_DEFAULT = 32;
  localparam int unsigned OUT_W_DEFAULT   = 24;

  typedef enum logic [1:0] {
    CMD_IDLE   = 2'b00,
    CMD_ON     = 2'b01,
    CMD_OFF    = 2'b10,
    CMD_ALLOFF = 2'b11
  } cmd_e;

  // round(2^32 * f(120+k) / 48 kHz), one entry per semitone of MIDI octave 10
  localparam logic [31:0] TW_TOP [12] = '{
    32'd749115498,  32'd793660223,  32'd840853716,  32'd890853481,
    32'd943826385,  32'd999949222,  32'd1059409297, 32'd1122405052,
    32'd1189146729, 32'd1259857073, 32'd1334772074, 32'd1414141751
  };

  function automatic logic [31:0] tw(input logic [6:0] n);
    logic [3:0] semi;
    logic [3:0] oct;
    semi = 4'(n % 7'd12);
    oct  = 4'(n / 7'd12);
    return TW_TOP[semi] >> (4'd10 - oct);
  endfunction

endpackage

// File: rtl/bank_manager_voice_alloc.sv
// Combinational voice search: which busy voices hold a given note, and
// which is the lowest-index free voice.
module voice_alloc #(
  parameter int unsigned NVOICES = 10
) (
  input  logic [NVOICES-1:0] busy,
  input  logic [6:0]         notes [NVOICES],
  input  logic [6:0]         note,
  output logic [NVOICES-1:0] match_mask,
  output logic [NVOICES-1:0] free_mask,
  output logic               free_any
);

  always_comb begin
    match_mask = '0;
    free_mask  = '0;
    free_any   = 1'b0;
    for (int unsigned i = 0; i < NVOICES; i++) begin
      match_mask[i] = busy[i] && (notes[i] == note);
      if (!busy[i] && !free_any) begin
        free_mask[i] = 1'b1;
        free_any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bank_manager.sv
// Voice bank: decodes host note commands into a pool of sawtooth phase
// accumulators and streams one voice sample per enabled clock, round-robin.
module bank_manager
  import bank_manager_pkg::*;
#(
  parameter int unsigned NVOICES = 10,
  parameter int unsigned PHASE_W = PHASE_W_DEFAULT,
  parameter int unsigned OUT_W   = OUT_W_DEFAULT
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clk_en,
  input  logic [15:0]             i_data,
  output logic signed [OUT_W-1:0] o_signal,
  output logic [3:0]              o_voice,
  output logic [NVOICES-1:0]      o_active
);

  logic [PHASE_W-1:0] phase  [NVOICES];
  logic [PHASE_W-1:0] tw_r   [NVOICES];
  logic [6:0]         note_r [NVOICES];
  logic [NVOICES-1:0] busy;
  logic [3:0]         slot;

  cmd_e               cmd;
  logic [6:0]         cmd_note;
  logic [NVOICES-1:0] match_mask;
  logic [NVOICES-1:0] free_mask;
  logic               free_any;
  logic [PHASE_W-1:0] cur_phase;
  logic               cur_busy;
  logic               unused_cmd_bits;

  assign cmd             = cmd_e'(i_data[15:14]);
  assign cmd_note        = i_data[6:0];
  assign unused_cmd_bits = ^i_data[13:7];
  assign o_active        = busy;

  voice_alloc #(
    .NVOICES(NVOICES)
  ) u_alloc (
    .busy      (busy),
    .notes     (note_r),
    .note      (cmd_note),
    .match_mask(match_mask),
    .free_mask (free_mask),
    .free_any  (free_any)
  );

  always_comb begin
    cur_phase = '0;
    cur_busy  = 1'b0;
    for (int unsigned i = 0; i < NVOICES; i++) begin
      if (slot == 4'(i)) begin
        cur_phase = phase[i];
        cur_busy  = busy[i];
      end
    end
  end

  // Command writes follow the accumulate so they win on the visited voice.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      o_signal <= '0;
      o_voice  <= '0;
      slot     <= '0;
      busy     <= '0;
      for (int unsigned i = 0; i < NVOICES; i++) begin
        phase[i]  <= '0;
        tw_r[i]   <= '0;
        note_r[i] <= '0;
      end
    end else begin
      if (clk_en) begin
        o_signal <= cur_busy ? cur_phase[PHASE_W-1 -: OUT_W] : '0;
        o_voice  <= slot;
        slot     <= (slot == 4'(NVOICES - 1)) ? '0 : slot + 4'd1;
        for (int unsigned i = 0; i < NVOICES; i++) begin
          if (slot == 4'(i) && busy[i]) begin
            phase[i] <= phase[i] + tw_r[i];
          end
        end
      end
      case (cmd)
        CMD_ON: begin
          if (|match_mask) begin
            for (int unsigned i = 0; i < NVOICES; i++) begin
              if (match_mask[i]) begin
                phase[i] <= '0;
              end
            end
          end else if (free_any) begin
            for (int unsigned i = 0; i < NVOICES; i++) begin
              if (free_mask[i]) begin
                note_r[i] <= cmd_note;
                tw_r[i]   <= PHASE_W'(tw(cmd_note));
                phase[i]  <= '0;
                busy[i]   <= 1'b1;
              end
            end
          end
        end
        CMD_OFF:    busy <= busy & ~match_mask;
        CMD_ALLOFF: busy <= '0;
        default:    ;
      endcase
    end
  end

endmodule

// File: tb/tb_bank_manager.sv
// Directed bench for bank_manager: round-robin stream, allocation, retrigger,
// note-off, stall behaviour and asynchronous reset.
module tb_bank_manager;

  logic               clk;
  logic               n_rst;
  logic               clk_en;
  logic [15:0]        i_data;
  logic signed [23:0] o_signal;
  logic [3:0]         o_voice;
  logic [9:0]         o_active;

  int vec_cnt = 0;
  int err_cnt = 0;

  // tw(69) = 1259857073 >> 5 ; tw(60) = 749115498 >> 5 ; values are phase[31:8]
  localparam logic [31:0] SIG69 [4] = '{32'd0, 32'd153791, 32'd307582, 32'd461373};
  localparam logic [31:0] SIG60_1 = 32'd91444;
  localparam logic [31:0] SIG60_2 = 32'd182889;

  bank_manager #(
    .NVOICES(10),
    .PHASE_W(32),
    .OUT_W  (24)
  ) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .clk_en  (clk_en),
    .i_data  (i_data),
    .o_signal(o_signal),
    .o_voice (o_voice),
    .o_active(o_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [15:0] word);
    i_data = word;
    tick();
    i_data = '0;
  endtask

  // Advance until the slot counter points at voice 0 (o_voice shows 9).
  task automatic wait_v9();
    int n = 0;
    while (o_voice != 4'd9 && n < 25) begin
      tick();
      n++;
    end
    if (n >= 25) chk("wait_v9", 32'(o_voice), 32'd9);
  endtask

  initial begin
    n_rst  = 1'b1;
    clk_en = 1'b0;
    i_data = '0;
    #1 n_rst = 1'b0;
    #2;
    chk("rst_sig", 32'(o_signal), 32'd0);
    chk("rst_voice", 32'(o_voice), 32'd0);
    chk("rst_active", 32'(o_active), 32'd0);
    #9;
    n_rst  = 1'b1;
    clk_en = 1'b1;

    // idle stream
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("idle_voice", 32'(o_voice), 32'(i % 10));
      chk("idle_sig", 32'(o_signal), 32'd0);
    end
    chk("idle_active", 32'(o_active), 32'd0);

    // single note 69 on voice 0; slot counter is at 0 here
    cmd(16'h4045);
    chk("on69_active", 32'(o_active), 32'h001);
    for (int t = 1; t <= 40; t++) begin
      tick();
      chk("on69_voice", 32'(o_voice), 32'(t % 10));
      if (t % 10 == 0) chk("on69_sig_v0", 32'(o_signal) & 32'hFFFFFF, SIG69[t/10 - 1]);
      else             chk("on69_sig_vx", 32'(o_signal), 32'd0);
    end

    // pool exhaustion, note-off, reuse
    cmd(16'hC000);
    chk("alloff_active", 32'(o_active), 32'd0);
    for (int n = 60; n <= 69; n++) cmd(16'h4000 | 16'(n));
    chk("full_active", 32'(o_active), 32'h3FF);
    cmd(16'h4046);
    chk("overflow_ignored", 32'(o_active), 32'h3FF);
    cmd(16'h803E);
    chk("off62_active", 32'(o_active), 32'h3FB);
    cmd(16'h7FD0);
    chk("reuse80_active", 32'(o_active), 32'h3FF);
    cmd(16'h8050);
    chk("off80_is_v2", 32'(o_active), 32'h3FB);
    cmd(16'h8046);
    chk("off70_absent", 32'(o_active), 32'h3FB);

    // retrigger of note 60
    cmd(16'hC000);
    cmd(16'h403C);
    wait_v9();
    tick();
    chk("n60_first", 32'(o_signal), 32'd0);
    wait_v9();
    tick();
    chk("n60_second", 32'(o_signal), SIG60_1);
    wait_v9();
    cmd(16'h403C);
    chk("n60_retrig_visit", 32'(o_signal), SIG60_2);
    chk("n60_retrig_voice", 32'(o_voice), 32'd0);
    chk("n60_single_voice", 32'(o_active), 32'h001);
    wait_v9();
    tick();
    chk("n60_restart", 32'(o_signal), 32'd0);
    cmd(16'hC000);
    chk("alloff2_active", 32'(o_active), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("alloff2_sig", 32'(o_signal), 32'd0);
    end

    // clk_en stall with a note-on issued mid-stall
    cmd(16'h4045);
    wait_v9();
    tick();
    chk("stall_pre0", 32'(o_signal), 32'd0);
    wait_v9();
    tick();
    chk("stall_pre1", 32'(o_signal) & 32'hFFFFFF, SIG69[1]);
    clk_en = 1'b0;
    for (int s = 0; s < 50; s++) begin
      if (s == 20) i_data = 16'h4048;
      tick();
      i_data = '0;
      if (s == 20) chk("stall_noteon", 32'(o_active), 32'h003);
      if (s % 10 == 9) begin
        chk("stall_sig", 32'(o_signal) & 32'hFFFFFF, SIG69[1]);
        chk("stall_voice", 32'(o_voice), 32'd0);
      end
    end
    clk_en = 1'b1;
    tick();
    chk("resume_voice", 32'(o_voice), 32'd1);
    chk("resume_sig_v1", 32'(o_signal), 32'd0);
    wait_v9();
    tick();
    chk("resume_phase_v0", 32'(o_signal) & 32'hFFFFFF, SIG69[2]);

    // asynchronous reset between edges
    #3 n_rst = 1'b0;
    #1;
    chk("arst_sig", 32'(o_signal), 32'd0);
    chk("arst_voice", 32'(o_voice), 32'd0);
    chk("arst_active", 32'(o_active), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3 n_rst = 1'b1;
    tick();
    chk("post_rst_voice", 32'(o_voice), 32'd0);
    chk("post_rst_sig", 32'(o_signal), 32'd0);
    tick();
    chk("post_rst_voice1", 32'(o_voice), 32'd1);
    chk("post_rst_active", 32'(o_active), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
